// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB encodings and the owner/control types for the bus-matrix output stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package ahb_bus_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P0   = 2'b01,
        P1   = 2'b10
    } owner_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } hresp_t;

    // Address-phase control bundle muxed alongside the address.
    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
    } ctrl_t;

endpackage

// File: rtl/ahb_bus_matrix_arb_rr2.sv
// Two-port round-robin address-phase arbiter with burst hold and optional lock (AHB_OUTSTAGE_LOCK_EN).
// Latency: next_owner is combinational from requests; state advances on ready edges.
// Backpressure: owner/last_grant/locked hold while ready is low.
module ahb_bus_matrix_arb_rr2
    import ahb_bus_matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       sel0,
    input  logic       sel1,
    input  logic [1:0] trans0,
    input  logic [1:0] trans1,
    input  logic       lock0,
    input  logic       lock1,
    output owner_t     next_owner
);

    owner_t     addr_owner;
    owner_t     last_grant;
    logic       locked;
    logic       req0;
    logic       req1;
    logic       own_sel;
    logic [1:0] own_trans;
    logic       rearb;

    assign req0 = sel0 && (trans0 != IDLE);
    assign req1 = sel1 && (trans1 != IDLE);

    always_comb begin
        own_sel   = 1'b0;
        own_trans = IDLE;
        case (addr_owner)
            P0: begin
                own_sel   = sel0;
                own_trans = trans0;
            end
            P1: begin
                own_sel   = sel1;
                own_trans = trans1;
            end
            default: ;
        endcase
    end

    // A burst in flight (SEQ/BUSY) keeps the port unless its owner walks away.
    assign rearb = !locked && ((addr_owner == NONE) || !own_sel ||
                               (own_trans == IDLE) || (own_trans == NONSEQ));

    always_comb begin
        next_owner = addr_owner;
        if (rst) begin
            next_owner = NONE;
        end else if (rearb) begin
            if (req0 && req1) begin
                if (last_grant == P0) next_owner = P1;
                else                  next_owner = P0;
            end else if (req0) begin
                next_owner = P0;
            end else if (req1) begin
                next_owner = P1;
            end else begin
                next_owner = NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_owner <= NONE;
            last_grant <= P1;
        end else if (ready) begin
            addr_owner <= next_owner;
            if (next_owner != NONE) last_grant <= next_owner;
        end
    end

`ifdef AHB_OUTSTAGE_LOCK_EN
    logic       nxt_lock;
    logic [1:0] nxt_trans;

    always_comb begin
        nxt_lock  = 1'b0;
        nxt_trans = IDLE;
        case (next_owner)
            P0: begin
                nxt_lock  = lock0;
                nxt_trans = trans0;
            end
            P1: begin
                nxt_lock  = lock1;
                nxt_trans = trans1;
            end
            default: ;
        endcase
    end

    // Locked IDLE cycles keep the lock; only an explicit lock=0 releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (ready && (next_owner != NONE)) begin
            if (!nxt_lock)               locked <= 1'b0;
            else if (nxt_trans != IDLE)  locked <= 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
    assign locked      = 1'b0;
`endif

endmodule

// File: rtl/ahb_bus_matrix_outstage_mi.sv
// Bus-matrix output stage for one slave port: arbitrates S0/S1, muxes address/control/wdata (lock via AHB_OUTSTAGE_LOCK_EN).
// Latency: address mux 0 cycles, write-data mux one HREADYS edge later, response path 0 cycles.
// Backpressure: HREADYS low freezes ownership and data-phase steering.
module ahb_bus_matrix_outstage_mi
    import ahb_bus_matrix_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              sel_op0,
    input  logic [ADDR_W-1:0] addr_op0,
    input  logic [1:0]        trans_op0,
    input  logic              write_op0,
    input  logic [2:0]        size_op0,
    input  logic [2:0]        burst_op0,
    input  logic [3:0]        prot_op0,
    input  logic              lock_op0,
    input  logic [DATA_W-1:0] wdata_op0,
    output logic              active_op0,
    input  logic              sel_op1,
    input  logic [ADDR_W-1:0] addr_op1,
    input  logic [1:0]        trans_op1,
    input  logic              write_op1,
    input  logic [2:0]        size_op1,
    input  logic [2:0]        burst_op1,
    input  logic [3:0]        prot_op1,
    input  logic              lock_op1,
    input  logic [DATA_W-1:0] wdata_op1,
    output logic              active_op1,
    input  logic              HREADYS,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic [DATA_W-1:0] HWDATAM,
    output logic              HREADYMUXM,
    input  logic              HREADYOUTM,
    input  logic [1:0]        HRESPM,
    input  logic [DATA_W-1:0] HRDATAM,
    output logic              readyout_op,
    output logic [1:0]        resp_op,
    output logic [DATA_W-1:0] rdata_op
);

    owner_t next_owner;
    owner_t data_owner;
    ctrl_t  ctrl0;
    ctrl_t  ctrl1;
    ctrl_t  ctrl_m;

    ahb_bus_matrix_arb_rr2 u_arb (
        .clk        (HCLK),
        .rst        (HRESET),
        .ready      (HREADYS),
        .sel0       (sel_op0),
        .sel1       (sel_op1),
        .trans0     (trans_op0),
        .trans1     (trans_op1),
        .lock0      (lock_op0),
        .lock1      (lock_op1),
        .next_owner (next_owner)
    );

    assign ctrl0 = {write_op0, size_op0, burst_op0, prot_op0};
    assign ctrl1 = {write_op1, size_op1, burst_op1, prot_op1};

    always_comb begin
        HSELM   = 1'b0;
        HADDRM  = '0;
        HTRANSM = IDLE;
        ctrl_m  = '0;
        case (next_owner)
            P0: begin
                HSELM   = 1'b1;
                HADDRM  = addr_op0;
                HTRANSM = trans_op0;
                ctrl_m  = ctrl0;
            end
            P1: begin
                HSELM   = 1'b1;
                HADDRM  = addr_op1;
                HTRANSM = trans_op1;
                ctrl_m  = ctrl1;
            end
            default: ;
        endcase
    end

    assign HWRITEM    = ctrl_m.write;
    assign HSIZEM     = ctrl_m.size;
    assign HBURSTM    = ctrl_m.burst;
    assign HPROTM     = ctrl_m.prot;
    assign active_op0 = (next_owner == P0);
    assign active_op1 = (next_owner == P1);

`ifdef AHB_OUTSTAGE_LOCK_EN
    assign HMASTLOCKM = (next_owner == P0) ? lock_op0 :
                        (next_owner == P1) ? lock_op1 : 1'b0;
`else
    assign HMASTLOCKM = 1'b0;
`endif

    // Write data belongs to the transfer accepted on the previous ready edge.
    always_ff @(posedge HCLK) begin
        if (HRESET)       data_owner <= NONE;
        else if (HREADYS) data_owner <= next_owner;
    end

    always_comb begin
        HWDATAM = '0;
        case (data_owner)
            P0:      HWDATAM = wdata_op0;
            P1:      HWDATAM = wdata_op1;
            default: ;
        endcase
    end

    assign HREADYMUXM  = HREADYOUTM;
    assign readyout_op = HREADYOUTM;
    assign resp_op     = HRESPM;
    assign rdata_op    = HRDATAM;

endmodule

// File: tb/tb_ahb_bus_matrix_outstage_mi.sv
// Bench for ahb_bus_matrix_outstage_mi: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a rule-level model of the output stage.
module tb_ahb_bus_matrix_outstage_mi;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
`ifdef AHB_OUTSTAGE_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESET;
    logic sel_op0, sel_op1, write_op0, write_op1, lock_op0, lock_op1;
    logic [AW-1:0] addr_op0, addr_op1;
    logic [1:0] trans_op0, trans_op1;
    logic [2:0] size_op0, size_op1, burst_op0, burst_op1;
    logic [3:0] prot_op0, prot_op1;
    logic [DW-1:0] wdata_op0, wdata_op1;
    logic active_op0, active_op1;
    logic HREADYS, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM, HREADYOUTM, readyout_op;
    logic [AW-1:0] HADDRM;
    logic [1:0] HTRANSM, HRESPM, resp_op;
    logic [2:0] HSIZEM, HBURSTM;
    logic [3:0] HPROTM;
    logic [DW-1:0] HWDATAM, HRDATAM, rdata_op;

    int tests = 0;
    int fails = 0;

    // Model state: owners as ints, 0 = nobody, 1 = port 0, 2 = port 1.
    int m_owner = 0;
    int m_last  = 2;
    int m_down  = 0;
    bit m_locked = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_outstage_mi #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .sel_op0(sel_op0), .addr_op0(addr_op0), .trans_op0(trans_op0), .write_op0(write_op0),
        .size_op0(size_op0), .burst_op0(burst_op0), .prot_op0(prot_op0), .lock_op0(lock_op0),
        .wdata_op0(wdata_op0), .active_op0(active_op0),
        .sel_op1(sel_op1), .addr_op1(addr_op1), .trans_op1(trans_op1), .write_op1(write_op1),
        .size_op1(size_op1), .burst_op1(burst_op1), .prot_op1(prot_op1), .lock_op1(lock_op1),
        .wdata_op1(wdata_op1), .active_op1(active_op1),
        .HREADYS(HREADYS), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
        .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
        .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM), .HREADYMUXM(HREADYMUXM),
        .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .HRDATAM(HRDATAM),
        .readyout_op(readyout_op), .resp_op(resp_op), .rdata_op(rdata_op)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who must own the address phase right now, from the arbitration rules.
    function automatic int exp_owner();
        bit r0, r1, o_sel, may_switch;
        logic [1:0] o_tr;
        if (HRESET) return 0;
        r0 = sel_op0 && (trans_op0 != T_IDLE);
        r1 = sel_op1 && (trans_op1 != T_IDLE);
        o_sel = (m_owner == 1) ? sel_op0 : (m_owner == 2) ? sel_op1 : 1'b0;
        o_tr  = (m_owner == 1) ? trans_op0 : (m_owner == 2) ? trans_op1 : T_IDLE;
        may_switch = !m_locked &&
                     (m_owner == 0 || !o_sel || o_tr == T_IDLE || o_tr == T_NONSEQ);
        if (!may_switch) return m_owner;
        if (r0 && r1) return (m_last == 1) ? 2 : 1;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    always @(posedge HCLK) begin
        int nx;
        bit lk;
        logic [1:0] tr;
        nx = exp_owner();
        if (HRESET) begin
            m_owner = 0; m_last = 2; m_down = 0; m_locked = 1'b0;
        end else if (HREADYS) begin
            if (LOCK_BUILD && nx != 0) begin
                lk = (nx == 1) ? lock_op0 : lock_op1;
                tr = (nx == 1) ? trans_op0 : trans_op1;
                if (!lk) m_locked = 1'b0;
                else if (tr != T_IDLE) m_locked = 1'b1;
            end
            m_owner = nx;
            if (nx != 0) m_last = nx;
            m_down = nx;
        end
    end

    always @(negedge HCLK) begin
        int nx;
        logic [10:0] c0, c1, ce;
        nx = exp_owner();
        c0 = {write_op0, size_op0, burst_op0, prot_op0};
        c1 = {write_op1, size_op1, burst_op1, prot_op1};
        ce = (nx == 1) ? c0 : (nx == 2) ? c1 : 11'd0;
        chk("m_hsel",   HSELM, nx != 0);
        chk("m_haddr",  HADDRM, (nx == 1) ? addr_op0 : (nx == 2) ? addr_op1 : '0);
        chk("m_htrans", HTRANSM, (nx == 1) ? trans_op0 : (nx == 2) ? trans_op1 : T_IDLE);
        chk("m_ctrl",   {HWRITEM, HSIZEM, HBURSTM, HPROTM}, ce);
        chk("m_lock",   HMASTLOCKM, LOCK_BUILD && ((nx == 1 && lock_op0) || (nx == 2 && lock_op1)));
        chk("m_active", {active_op1, active_op0}, {nx == 2, nx == 1});
        chk("m_hwdata", HWDATAM, (m_down == 1) ? wdata_op0 : (m_down == 2) ? wdata_op1 : '0);
        chk("m_resp",   {HREADYMUXM, readyout_op, resp_op, rdata_op},
                        {HREADYOUTM, HREADYOUTM, HRESPM, HRDATAM});
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic p0(input bit s, input logic [1:0] t, input logic [AW-1:0] a, input bit w, input bit l);
        sel_op0 = s; trans_op0 = t; addr_op0 = a; write_op0 = w; lock_op0 = l;
    endtask

    task automatic p1(input bit s, input logic [1:0] t, input logic [AW-1:0] a, input bit w, input bit l);
        sel_op1 = s; trans_op1 = t; addr_op1 = a; write_op1 = w; lock_op1 = l;
    endtask

    task automatic do_reset();
        step();
        HRESET = 1'b1;
        p0(0, T_IDLE, '0, 0, 0);
        p1(0, T_IDLE, '0, 0, 0);
        HREADYS = 1'b1; HREADYOUTM = 1'b1;
        step();
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; HREADYS = 1'b1; HREADYOUTM = 1'b1; HRESPM = 2'b00; HRDATAM = '0;
        p0(0, T_IDLE, '0, 0, 0); p1(0, T_IDLE, '0, 0, 0);
        size_op0 = 3'd2; size_op1 = 3'd2; burst_op0 = 3'd0; burst_op1 = 3'd0;
        prot_op0 = 4'h3; prot_op1 = 4'h3; wdata_op0 = '0; wdata_op1 = '0;
        step(); step();
        @(negedge HCLK);
        chk("rst_hsel", HSELM, 0);
        chk("rst_htrans", HTRANSM, 0);
        chk("rst_active", {active_op1, active_op0}, 0);
        chk("rst_hwdata", HWDATAM, 0);

        // Single read from port 0: address appears in the same cycle.
        step();
        HRESET = 1'b0;
        p0(1, T_NONSEQ, 32'h100, 0, 0);
        @(negedge HCLK);
        chk("rd_haddr", HADDRM, 32'h100);
        chk("rd_active0", active_op0, 1);
        step();
        p0(1, T_IDLE, '0, 0, 0);
        HRDATAM = 32'hCAFE_0100;
        @(negedge HCLK);
        chk("rd_rdata", rdata_op, 32'hCAFE_0100);
        chk("rd_idle_hsel", HSELM, 0);

        // Both ports streaming NONSEQ singles: grants alternate starting with port 0.
        do_reset();
        wdata_op0 = 32'hA0; wdata_op1 = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            step();
            p0(1, T_NONSEQ, 32'h1000 + i, 1, 0);
            p1(1, T_NONSEQ, 32'h2000 + i, 1, 0);
            @(negedge HCLK);
            chk("rr_active0", active_op0, (i % 2) == 0);
            if (i > 0) chk("rr_hwdata", HWDATAM, (i % 2 == 1) ? 32'hA0 : 32'hB1);
        end
        step();
        p0(0, T_IDLE, '0, 0, 0); p1(0, T_IDLE, '0, 0, 0);
        @(negedge HCLK);
        chk("rr_last_hwdata", HWDATAM, 32'hB1);

        // INCR4 from port 0 holds off a waiting port 1 until the burst ends.
        do_reset();
        burst_op0 = 3'b011;
        for (int i = 0; i < 5; i++) begin
            step();
            p0(i < 4, (i == 0) ? T_NONSEQ : (i < 4) ? T_SEQ : T_IDLE, 32'h500 + 4 * i, 0, 0);
            p1(1, T_NONSEQ, 32'h600, 0, 0);
            @(negedge HCLK);
            chk("burst_active1", active_op1, i == 4);
            if (i == 2) chk("burst_htrans", HTRANSM, T_SEQ);
        end
        burst_op0 = 3'b000;

        // Wait states during port 1 writes: everything holds.
        do_reset();
        step();
        p1(1, T_NONSEQ, 32'h200, 1, 0);
        step();
        p1(1, T_NONSEQ, 32'h204, 1, 0);
        wdata_op1 = 32'h2222_0200;
        HREADYS = 1'b0; HREADYOUTM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin HREADYS = 1'b1; HREADYOUTM = 1'b1; end
            @(negedge HCLK);
            chk("wait_haddr", HADDRM, 32'h204);
            chk("wait_hwdata", HWDATAM, 32'h2222_0200);
            chk("wait_active1", active_op1, 1);
            if (i < 2) chk("wait_readymux", HREADYMUXM, 0);
            step();
        end
        p1(0, T_IDLE, '0, 0, 0);
        wdata_op1 = 32'h3333_0204;
        @(negedge HCLK);
        chk("wait_done_hwdata", HWDATAM, 32'h3333_0204);

        // Locked sequence from port 0 while port 1 keeps requesting.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            case (i)
                0: p0(1, T_NONSEQ, 32'h300, 0, 1);
                1: p0(1, T_IDLE,   32'h300, 0, 1);
                2: p0(1, T_NONSEQ, 32'h304, 0, 0);
                default: p0(0, T_IDLE, '0, 0, 0);
            endcase
            p1(1, T_NONSEQ, 32'h400, 0, 0);
            @(negedge HCLK);
            if (i == 0) chk("lock_hmastlock", HMASTLOCKM, LOCK_BUILD);
            chk("lock_active1", active_op1, (i == 3) || (i == 1 && !LOCK_BUILD));
        end

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            HRESET     = ($urandom_range(0, 199) == 0);
            HREADYS    = ($urandom_range(0, 3) != 0);
            HREADYOUTM = ($urandom_range(0, 3) != 0);
            HRESPM     = 2'($urandom_range(0, 1));
            HRDATAM    = $urandom;
            p0($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            p1($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            size_op0 = 3'($urandom); size_op1 = 3'($urandom);
            burst_op0 = 3'($urandom); burst_op1 = 3'($urandom);
            prot_op0 = 4'($urandom); prot_op1 = 4'($urandom);
            wdata_op0 = $urandom; wdata_op1 = $urandom;
        end
        step();
        @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
